// File: rtl/neuron_accum_act.sv
// neuron_accum_act: accumulates adder-tree chunk sums per neuron, thresholds the
// neuron total into a binary activation and packs activations LSB-first into
// words handed off over a valid/ready port. Neuron tags ride a delay line so
// they line up with the tree output.
//
// Output handshake: out_valid/out_word/out_bits form a valid/ready source. A word
// transfers on any cycle with out_valid && out_ready; while out_valid && !out_ready
// the presented word and bit count are held stable. The upstream tree is never
// stalled, so a word completing while the held word is still unaccepted is
// dropped and recorded in the sticky overflow flag.
module neuron_accum_act #(
    parameter  int WIDTH_IN = 8,
    parameter  int ACC_W    = WIDTH_IN + 19,
    parameter  int TREE_LAT = 4,
    parameter  int OUT_W    = 8,
    localparam int SUM_W    = WIDTH_IN + 11,
    localparam int BITS_W   = $clog2(OUT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tag_valid,
    input  logic              tag_last,
    input  logic              tag_flush,
    input  logic [ACC_W-1:0]  tag_thresh,
    input  logic [SUM_W-1:0]  sum_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_word,
    output logic [BITS_W-1:0] out_bits,
    output logic              overflow,
    input  logic              clr_err
);

    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    // Tag delay line; the last stage describes the chunk currently on sum_in.
    logic [TREE_LAT-1:0]            v_q, l_q, f_q;
    logic [TREE_LAT-1:0][ACC_W-1:0] th_q;

    // Neuron accumulation and word packing state.
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  partial_q, partial_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Output register.
    logic              valid_q, valid_d;
    logic [OUT_W-1:0]  word_q, word_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              ovf_q, ovf_d;

    // Datapath intermediates.
    logic              d_valid, d_last, d_flush;
    logic [ACC_W-1:0]  d_thresh;
    logic [ACC_W-1:0]  sum_ext, total;
    logic              act;
    logic [OUT_W-1:0]  word_new;
    logic [BITS_W-1:0] bits_new;
    logic              complete, drop, accept;

    // Shift the tags down the delay line every cycle; no stalls exist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            l_q  <= '0;
            f_q  <= '0;
            th_q <= '0;
        end else begin
            for (int i = TREE_LAT - 1; i > 0; i--) begin
                v_q[i]  <= v_q[i-1];
                l_q[i]  <= l_q[i-1];
                f_q[i]  <= f_q[i-1];
                th_q[i] <= th_q[i-1];
            end
            v_q[0]  <= tag_valid;
            l_q[0]  <= tag_last;
            f_q[0]  <= tag_flush;
            th_q[0] <= tag_thresh;
        end
    end

    // Accumulate the aligned chunk, decide the activation and pack it.
    always_comb begin
        d_valid   = v_q[TREE_LAT-1];
        d_last    = l_q[TREE_LAT-1];
        d_flush   = f_q[TREE_LAT-1];
        d_thresh  = th_q[TREE_LAT-1];
        sum_ext   = {{(ACC_W-SUM_W){sum_in[SUM_W-1]}}, sum_in};
        total     = acc_q + sum_ext;
        act       = ($signed(total) >= $signed(d_thresh));
        word_new  = partial_q;
        word_new[cnt_q] = act;
        bits_new  = BITS_W'(cnt_q) + BITS_W'(1);
        // flush only takes effect on a neuron's final chunk
        complete  = d_valid && d_last && ((cnt_q == CNT_W'(OUT_W - 1)) || d_flush);
        acc_d     = acc_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        if (d_valid) begin
            if (!d_last) begin
                acc_d = total;
            end else begin
                acc_d = '0;
                if (complete) begin
                    partial_d = '0;
                    cnt_d     = '0;
                end else begin
                    partial_d = word_new;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Output register: load completed words, retire accepted ones, flag drops.
    always_comb begin
        accept  = valid_q && out_ready;
        drop    = complete && valid_q && !out_ready;
        valid_d = valid_q;
        word_d  = word_q;
        bits_d  = bits_q;
        if (complete && !drop) begin
            valid_d = 1'b1;
            word_d  = word_new;
            bits_d  = bits_new;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        ovf_d = ovf_q;
        if (clr_err) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // State registers for accumulation, packing and output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            bits_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
            bits_q    <= bits_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign out_bits  = bits_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_neuron_accum_act.sv
// Directed bench for neuron_accum_act. Each tag is paired with the sum the tree
// would produce for it; the bench delays that sum by TREE_LAT cycles itself so
// the DUT sees it on the matching cycle. Idle cycles carry a junk sum.
module tb_neuron_accum_act;

    localparam int WIDTH_IN = 8;
    localparam int ACC_W    = WIDTH_IN + 19;
    localparam int TREE_LAT = 4;
    localparam int OUT_W    = 8;
    localparam int SUM_W    = WIDTH_IN + 11;
    localparam int BITS_W   = $clog2(OUT_W + 1);
    localparam int JUNK     = 12345;

    logic              clk;
    logic              rst_n;
    logic              tag_valid, tag_last, tag_flush;
    logic [ACC_W-1:0]  tag_thresh;
    logic [SUM_W-1:0]  sum_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_word;
    logic [BITS_W-1:0] out_bits;
    logic              overflow;
    logic              clr_err;

    logic [SUM_W-1:0]  sdly [TREE_LAT];

    int checks = 0;
    int errors = 0;

    neuron_accum_act #(
        .WIDTH_IN (WIDTH_IN),
        .ACC_W    (ACC_W),
        .TREE_LAT (TREE_LAT),
        .OUT_W    (OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_valid  (tag_valid),
        .tag_last   (tag_last),
        .tag_flush  (tag_flush),
        .tag_thresh (tag_thresh),
        .sum_in     (sum_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_bits   (out_bits),
        .overflow   (overflow),
        .clr_err    (clr_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present a tag, feed the sum of the tag sampled TREE_LAT edges ago.
    task automatic cyc(input logic v, input logic l, input logic f, input int th, input int s);
        tag_valid  = v;
        tag_last   = l;
        tag_flush  = f;
        tag_thresh = ACC_W'(th);
        sum_in     = sdly[TREE_LAT-1];
        @(posedge clk);
        for (int i = TREE_LAT - 1; i > 0; i--) sdly[i] = sdly[i-1];
        sdly[0] = SUM_W'(s);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, JUNK);
    endtask

    // Issue eight single-chunk neurons, thresh 0, positive sum where bit set.
    task automatic word8(input logic [7:0] pattern);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 0, pattern[i] ? 5 : -3);
    endtask

    initial begin
        rst_n      = 1'b0;
        tag_valid  = 1'b0;
        tag_last   = 1'b0;
        tag_flush  = 1'b0;
        tag_thresh = '0;
        sum_in     = '0;
        out_ready  = 1'b0;
        clr_err    = 1'b0;
        for (int i = 0; i < TREE_LAT; i++) sdly[i] = SUM_W'(JUNK);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_word",  out_word,  0);
        chk("rst_bits",  out_bits,  0);
        chk("rst_ovf",   overflow,  0);
        rst_n = 1'b1;
        idle(2);

        // word packing: acts 1,0,1,0,... -> 0x55, exact latency
        word8(8'h55);
        idle(3);
        chk("pack_early_valid", out_valid, 0);
        idle(1);
        chk("pack_valid", out_valid, 1);
        chk("pack_word",  out_word,  32'h55);
        chk("pack_bits",  out_bits,  8);
        out_ready = 1'b1;
        idle(1);
        chk("pack_xfer_valid", out_valid, 0);

        // multi-chunk with threshold edge: total -10 -> 0, total -9 -> 1
        cyc(1'b1, 1'b0, 1'b0, 0, 100);
        cyc(1'b1, 1'b0, 1'b0, 0, -50);
        cyc(1'b1, 1'b1, 1'b0, -9, -60);
        cyc(1'b1, 1'b0, 1'b0, 0, 100);
        cyc(1'b1, 1'b0, 1'b0, 0, -50);
        cyc(1'b1, 1'b1, 1'b1, -9, -59);
        idle(4);
        chk("thr_valid", out_valid, 1);
        chk("thr_word",  out_word,  32'h02);
        chk("thr_bits",  out_bits,  2);
        idle(1);
        chk("thr_xfer_valid", out_valid, 0);

        // flush partial word 1,0,1 -> 0x05; next neuron starts at bit 0
        cyc(1'b1, 1'b1, 1'b0, 0, 5);
        cyc(1'b1, 1'b1, 1'b0, 0, -3);
        cyc(1'b1, 1'b1, 1'b1, 0, 5);
        idle(4);
        chk("flush_word", out_word, 32'h05);
        chk("flush_bits", out_bits, 3);
        cyc(1'b1, 1'b1, 1'b1, 0, 7);
        idle(4);
        chk("fresh_valid", out_valid, 1);
        chk("fresh_word",  out_word,  32'h01);
        chk("fresh_bits",  out_bits,  1);
        idle(2);

        // backpressure: two full words, second dropped
        out_ready = 1'b0;
        word8(8'h55);
        word8(8'hFF);
        idle(6);
        chk("bp_valid", out_valid, 1);
        chk("bp_word",  out_word,  32'h55);
        chk("bp_bits",  out_bits,  8);
        chk("bp_ovf",   overflow,  1);
        out_ready = 1'b1;
        idle(1);
        chk("bp_one_xfer", out_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);
        idle(2);
        chk("bp_no_second", out_valid, 0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("bp_clr", overflow, 0);

        // same-cycle accept and load
        out_ready = 1'b0;
        word8(8'hFF);
        word8(8'hAA);
        idle(3);
        chk("sc_held_word", out_word, 32'hFF);
        out_ready = 1'b1;
        idle(1);
        chk("sc_valid", out_valid, 1);
        chk("sc_word",  out_word,  32'hAA);
        chk("sc_ovf",   overflow,  0);
        idle(1);
        chk("sc_drain", out_valid, 0);

        // reset mid-neuron with a word held at the output
        out_ready = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 0, 5);
        cyc(1'b1, 1'b0, 1'b0, 0, 1000);
        cyc(1'b1, 1'b0, 1'b0, 0, 1000);
        idle(4);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_word",  out_word,  0);
        chk("mid_rst_bits",  out_bits,  0);
        chk("mid_rst_ovf",   overflow,  0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 2, 1);
        idle(4);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_word",  out_word,  32'h00);
        chk("post_rst_bits",  out_bits,  1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_accum_act.md
Name: neuron_accum_act

Overview:
- Downstream consumer of the 256-input pipelined adder tree in the binary-net datapath.
- Accumulates successive 256-input tree sums (chunks) belonging to one neuron and compares the total against a per-neuron threshold to produce a binary activation.
- Packs activations LSB-first into words and hands them off over a valid/ready interface.
- Neuron tags (valid/last/flush/threshold) enter alongside the tree inputs and are delayed internally to align with the tree output.

Parameters:
- WIDTH_IN, 8, tree element base width; tree sum width SUM_W = WIDTH_IN+11.
- ACC_W, WIDTH_IN+19, accumulator and threshold width (two's complement).
- TREE_LAT, 4, cycles from tree input to tree output; tag delay depth.
- OUT_W, 8, activations per output word.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tag_valid  in  1  a chunk enters the tree this cycle.
- tag_last  in  1  this chunk is the neuron's final chunk.
- tag_flush  in  1  with tag_last: emit the partial word after this neuron.
- tag_thresh  in  ACC_W  signed threshold; meaningful only with tag_last.
- sum_in  in  SUM_W  signed tree output.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts.
- out_word  out  OUT_W  packed activations; bit i is the i-th neuron of the word.
- out_bits  out  $clog2(OUT_W+1)  count of valid bits in out_word.
- overflow  out  1  sticky: a completed word was dropped.
- clr_err  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: out_valid=0, out_word=0, out_bits=0, overflow=0; accumulator, bit counter, partial word and all tag-pipe valids cleared.
- Reset mid-operation discards in-flight tags, partial sums and the partial word.
- Tag pipe:
  - TREE_LAT-stage shift of {valid, last, flush, thresh}.
  - A tag sampled at edge t qualifies sum_in at cycle t+TREE_LAT (the "D-cycle").
  - sum_in is ignored when the delayed valid is 0.
- D-cycle arithmetic: total = acc + sign-extend(sum_in) at ACC_W, wrapping two's complement (no saturation).
  - last=0: acc <= total.
  - last=1: act = (total >= thresh, signed); acc <= 0; act is written to partial[bit_cnt]; bit_cnt increments.
- Word completion happens on a last D-cycle when bit_cnt+1 == OUT_W, or when flush=1.
  - The completed word is {act inserted, higher bits 0}; out_bits = bit_cnt+1.
  - Partial word and bit_cnt reset to 0.
  - flush with last=0 is ignored.
- Load rule: a completed word loads into the output register at the D-cycle edge, so out_valid rises at t+TREE_LAT+1 relative to the final tag.
- Output handshake:
  - out_word and out_bits stay stable while out_valid && !out_ready.
  - Transfer occurs when out_valid && out_ready. Without a new word, out_valid falls next cycle.
  - Transfer and completion in the same cycle: the new word loads, out_valid stays 1, no overflow.
  - Completion while out_valid && !out_ready: the held word is kept, the new word is dropped, overflow <= 1.
- overflow clears only on clr_err or reset. If clr_err and a new drop coincide, the set wins.
- No backpressure to the upstream tree; tags are never stalled.

Test Plan:
- Word packing: 8 single-chunk neurons, thresh=0, sums 5,-3,5,-3,5,-3,5,-3, tags on consecutive cycles t0..t7 -> out_valid at t7+5, out_word=0x55, out_bits=8.
- Multi-chunk threshold edge: chunks 100,-50,-60 with thresh=-9 -> act 0 (total -10). Next neuron 100,-50,-59 -> act 1 (total -9, equal counts as 1). With flush on the second neuron -> out_word=0x02, out_bits=2.
- Flush partial word: neurons with acts 1,0,1 and flush on the third -> out_word=0x05, out_bits=3. The following neuron lands at bit 0 of a fresh word.
- Backpressure:
  - Hold out_ready=0 while two full words complete -> first word held unchanged, second dropped, overflow=1.
  - Then out_ready=1 -> one transfer.
  - Then clr_err pulse -> overflow=0.
- Same-cycle accept and load: out_ready=1 on the exact cycle a second word completes -> out_valid stays 1, new word presented, overflow stays 0.
- Reset mid-neuron: after 2 of 3 chunks (sums 1000,1000), pulse rst_n low -> all outputs 0. Then single-chunk neuron sum=1, thresh=2, flush -> act 0, out_word=0x00, out_bits=1 (pre-reset sums not included).
